// File: rtl/decode_pkg.sv
// decode_pkg: shared types for the RV32I decode stage.
// Opcodes, ALU op / immediate format enums, control and ID/EX bundles.
package decode_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src_imm;
        logic [1:0] wb_sel;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        alu_op_e         alu_op;
        ctrl_t           ctrl;
        logic            illegal;
    } id_ex_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] i,
                                            input imm_fmt_e fmt);
        logic [31:0] r;
        case (fmt)
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = {{20{i[31]}}, i[31:20]};
        endcase
        return r;
    endfunction

    // alt selects SUB/SRA; callers decide when instr[30] is meaningful
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                            input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 2R1W architectural register file, x0 reads zero.
// WB_BYPASS_EN forwards a same-cycle writeback to a matching read port.
module decode_regfile
    import decode_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr;

    assign wr = wb_en && (wb_rd != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`ifdef WB_BYPASS_EN
        if (wr && wb_rd == rs1_addr) rs1_data = wb_data;
        if (wr && wb_rd == rs2_addr) rs2_data = wb_data;
`endif
    end

endmodule

// File: rtl/decode.sv
// decode: RV32I decode stage, register file read and ID/EX register.
// Optional macro WB_BYPASS_EN enables same-cycle writeback bypass.
module decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output alu_op_e     alu_op,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        live;
    logic        f7_ok;
    ctrl_t       d_ctrl;
    alu_op_e     d_alu;
    imm_fmt_e    d_fmt;
    logic        d_ill;
    id_ex_t      d;
    id_ex_t      q;

    assign opcode = instr_in[6:0];
    assign f3     = instr_in[14:12];
    assign f7     = instr_in[31:25];
    // an all-zero word is the fetch bubble, never a real instruction
    assign live   = valid_in && (instr_in != 32'd0);
    assign f7_ok  = (f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

    decode_regfile u_rf (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (instr_in[19:15]),
        .rs2_addr (instr_in[24:20]),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1_data (rd1),
        .rs2_data (rd2)
    );

    always_comb begin
        d_ctrl = '0;
        d_alu  = ALU_ADD;
        d_fmt  = IMM_I;
        d_ill  = 1'b0;
        unique case (1'b1)
            (opcode == OPC_LUI): begin
                d_fmt = IMM_U;
                d_alu = ALU_PASSB;
                d_ctrl.reg_write   = 1'b1;
                d_ctrl.alu_src_imm = 1'b1;
            end
            (opcode == OPC_AUIPC): begin
                d_fmt = IMM_U;
                d_ctrl.reg_write   = 1'b1;
                d_ctrl.alu_src_imm = 1'b1;
            end
            (opcode == OPC_JAL): begin
                d_fmt = IMM_J;
                d_ctrl.reg_write = 1'b1;
                d_ctrl.jump      = 1'b1;
                d_ctrl.wb_sel    = WB_PC4;
            end
            (opcode == OPC_JALR): begin
                d_ctrl.reg_write   = 1'b1;
                d_ctrl.jump        = 1'b1;
                d_ctrl.alu_src_imm = 1'b1;
                d_ctrl.wb_sel      = WB_PC4;
            end
            (opcode == OPC_BRANCH): begin
                d_fmt = IMM_B;
                d_alu = ALU_SUB;
                d_ctrl.branch = 1'b1;
            end
            (opcode == OPC_LOAD): begin
                d_ctrl.reg_write   = 1'b1;
                d_ctrl.mem_read    = 1'b1;
                d_ctrl.alu_src_imm = 1'b1;
                d_ctrl.wb_sel      = WB_MEM;
            end
            (opcode == OPC_STORE): begin
                d_fmt = IMM_S;
                d_ctrl.mem_write   = 1'b1;
                d_ctrl.alu_src_imm = 1'b1;
            end
            (opcode == OPC_OP_IMM): begin
                d_alu = alu_from_f3(f3, f3 == 3'b101 && instr_in[30]);
                d_ctrl.reg_write   = 1'b1;
                d_ctrl.alu_src_imm = 1'b1;
            end
            (opcode == OPC_OP): begin
                if (f7_ok) begin
                    d_alu = alu_from_f3(f3, instr_in[30]);
                    d_ctrl.reg_write = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            default: d_ill = 1'b1;
        endcase
    end

    always_comb begin
        d          = '0;
        d.valid    = live;
        d.pc       = pc_in;
        d.rs1_data = rd1;
        d.rs2_data = rd2;
        d.imm      = gen_imm(instr_in, d_fmt);
        d.rs1      = instr_in[19:15];
        d.rs2      = instr_in[24:20];
        d.rd       = instr_in[11:7];
        d.alu_op   = d_alu;
        d.ctrl     = live ? d_ctrl : '0;
        d.illegal  = live && d_ill;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

    assign valid_out = q.valid;
    assign pc_out    = q.pc;
    assign rs1_data  = q.rs1_data;
    assign rs2_data  = q.rs2_data;
    assign imm       = q.imm;
    assign rs1       = q.rs1;
    assign rs2       = q.rs2;
    assign rd        = q.rd;
    assign alu_op    = q.alu_op;
    assign ctrl      = q.ctrl;
    assign illegal   = q.illegal;

endmodule
